ifetch_ctrl: RTL
================

# ifetch_ctrl

Instruction-fetch controller that sequences the 64-word instruction ROM (6-bit word address, 32-bit combinational read data) for the MIPS core. It owns the fetch program counter, drives the ROM address, and buffers fetched words in a small FIFO. It hands `{pc, instr}` pairs to decode over a valid/ready handshake and accepts branch/jump redirects that flush in-flight words.

## Interface
- `DEPTH`, 2: prefetch FIFO entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: pulse; IDLE→RUN.
- `stop` input 1: pulse; RUN/FULL→IDLE (fetching stops, FIFO keeps draining).
- `iram_addr` output 6: ROM word address, equals `fetch_pc[7:2]`.
- `iram_data` input 32: ROM read data, combinational from `iram_addr`, same cycle.
- `instr` output 32: FIFO head instruction; 0 when empty.
- `instr_pc` output 32: byte PC of `instr`; 0 when empty.
- `instr_valid` output 1: FIFO non-empty.
- `instr_ready` input 1: decode accepts head this cycle.
- `redirect_valid` input 1: branch/jump taken.
- `redirect_pc` input 32: target byte PC; bits [1:0] ignored (forced 0).
- `busy` output 1: state ≠ IDLE.
- `fetch_cnt` output 16: words pushed since reset, wraps at 2^16.

## Operation
- States: IDLE, RUN, FULL (all registered). Reset→IDLE.
- IDLE: no push. `start`→RUN. `redirect_valid` still updates `fetch_pc` and flushes.
- RUN: each cycle with push allowed, `{fetch_pc, iram_data}` written to FIFO tail, `fetch_pc += 4`, `fetch_cnt += 1`.
- Push allowed = state RUN and (count < DEPTH, or pop in same cycle). FIFO full with no pop → FULL.
- FULL: no push; pop → RUN next cycle (push resumes the cycle after).
- `stop` from RUN or FULL → IDLE; `stop` has no effect in IDLE. `start` and `stop` together: `stop` wins.
- Pop: `instr_valid & instr_ready`; head removed at clock edge.
- Redirect (highest priority): FIFO flushed (count=0), no push and no pop that cycle, `fetch_pc ← {redirect_pc[31:2],2'b00}`. FULL→RUN; IDLE stays IDLE. `fetch_cnt` unaffected.
- Redirect and `stop` together: both applied (PC loaded, FIFO flushed, →IDLE).
- `fetch_pc` is a full 32-bit register. `iram_addr` wraps modulo 64 words (PC 0x100 reads word 0). `fetch_pc` wraps at 2^32.
- Reset mid-operation: FIFO flushed, state IDLE, all outputs to reset values on the next edge; no partial push.

## Timing
- Reset values: `iram_addr`=RESET_PC[7:2] (0), `instr`=0, `instr_pc`=0, `instr_valid`=0, `busy`=0, `fetch_cnt`=0.
- `start` sampled in cycle N → RUN in N+1. Word at RESET_PC pushed at end of N+1 → `instr_valid`=1 in N+2.
- Sustained throughput: 1 word/cycle with `instr_ready` held high. FIFO count stays 1.
- Redirect in cycle R: `instr_valid`=0 in R+1, target word fetched in R+1, valid in R+2 (state RUN).
- `instr`/`instr_pc`/`instr_valid` are functions of registered FIFO state only. No combinational path from `instr_ready` or `redirect_*` to outputs.
- `iram_addr` is a registered-PC function, so the ROM read settles within the same cycle.

## Test plan
- Reset, `start`, `instr_ready`=1 for 6 cycles → `instr_pc` 0,4,8,…,0x14 on consecutive cycles from N+2. `instr` matches ROM words 0..5 (0x20020005, 0x20070003, …). `fetch_cnt`=6.
- `start`, `instr_ready`=0 → two pushes (pc 0, 4), state FULL, `fetch_pc`=8. Raise ready → pops pc 0, 4, then 8 with no gap or duplicate.
- Redirect to 0x3C while FIFO holds pc 0x10, 0x14 → both dropped. `instr_valid` low one cycle, then `instr_pc`=0x3C, `instr`=0xAC470047.
- Redirect to 0xFE → low bits ignored, PC 0xFC, `iram_addr`=63. Next word at PC 0x100 has `iram_addr`=0 (wrap), and `instr_pc` reads 0x100.
- `stop` while running with ready=0 → no further pushes, `busy`=0, buffered words still pop on ready. `start` resumes at the saved `fetch_pc`.
- Assert `reset` mid-stream with a full FIFO → next cycle `instr_valid`=0, `fetch_cnt`=0, `iram_addr`=0, state IDLE. Fetch resumes only after `start`.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads the ROM and
// buffers {pc, instr} pairs in a small FIFO for decode.
module ifetch_ctrl #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [5:0]  iram_addr,
  input  logic [31:0] iram_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic [15:0] fetch_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DCNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [15:0]  fcnt_q, fcnt_d;
  logic [AW:0]  cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [31:0]  pc_mem_q  [DEPTH];
  logic [31:0]  ins_mem_q [DEPTH];

  logic pop;
  logic push;

  assign instr_valid = (cnt_q != '0);
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = (state_q == S_RUN) & ~redirect_valid
              & ((cnt_q < DCNT) | pop);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start & ~stop & ~redirect_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop)                 state_d = S_IDLE;
        else if (redirect_valid)  state_d = S_RUN;
        else if (cnt_d == DCNT)   state_d = S_FULL;
      end
      S_FULL: begin
        if (stop)                       state_d = S_IDLE;
        else if (redirect_valid | pop)  state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    fpc_d  = fpc_q;
    fcnt_d = fcnt_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    if (redirect_valid) begin
      fpc_d = {redirect_pc[31:2], 2'b00};
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      if (push) begin
        fpc_d  = fpc_q + 32'd4;
        fcnt_d = fcnt_q + 16'd1;
        wr_d   = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      if (push & ~pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (pop & ~push) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q  <= RESET_PC;
      fcnt_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      fpc_q  <= fpc_d;
      fcnt_q <= fcnt_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  // Storage needs no reset: entries are only visible while cnt_q > 0.
  always_ff @(posedge clk) begin
    if (push & ~reset) begin
      pc_mem_q[wr_q]  <= fpc_q;
      ins_mem_q[wr_q] <= iram_data;
    end
  end

  assign iram_addr = fpc_q[7:2];
  assign fetch_cnt = fcnt_q;
  assign instr     = instr_valid ? ins_mem_q[rd_q] : '0;
  assign instr_pc  = instr_valid ? pc_mem_q[rd_q]  : '0;

endmodule
